ex_mem_stage_reg: RTL

Pipeline register between the 32-bit ALU (built from ripple-connected 1-bit slices) and the data-memory stage. Captures the ALU result, its status flags (CarryOut, Overflow, Set) and the forwarded control and store-data fields, and presents them to the memory stage with a valid/ready handshake. A 2-entry skid buffer keeps `in_ready` registered and sustains one transfer per cycle. Supports a synchronous flush for branch redirects.

---
 rtl/ex_mem_pkg.sv | 40 ++++
 rtl/ex_mem_skid.sv | 98 +++++++++
 rtl/ex_mem_stage_reg.sv | 113 +++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
//------------------------------------------------------------------------------
// Module   : ex_mem_pkg
// Purpose  : Shared types and constants for the EX/MEM pipeline register.
//            - XLEN_DEF / REG_ADDR_W_DEF : default datapath and register-index widths
//            - ex_mem_payload_t          : everything carried from EX to MEM
//            - occ_state_t               : skid-buffer occupancy (EMPTY/ONE/TWO)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ex_mem_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0]       alu_result;
    logic                      alu_carry;
    logic                      alu_overflow;
    logic                      alu_set;
    logic [XLEN_DEF-1:0]       store_data;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      is_addsub;
    logic                      zero;
    logic                      trap;
  } ex_mem_payload_t;

endpackage

`default_nettype wire

// File: rtl/ex_mem_skid.sv
//------------------------------------------------------------------------------
// Module   : ex_mem_skid
// Purpose  : Two-entry skid buffer carrying ex_mem_payload_t with a
//            valid/ready handshake on both sides. in_ready is a flop output.
// Ports    : clk, reset (async, active-high), flush (sync)
//            in_valid / in_ready / in_data   : upstream side
//            out_valid / out_ready / out_data: downstream side (main entry)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_skid
  import ex_mem_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  ex_mem_payload_t in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output ex_mem_payload_t out_data
);

  occ_state_t      state_q, state_d;
  logic            in_ready_q, in_ready_d;
  ex_mem_payload_t main_q, main_d;
  ex_mem_payload_t skid_q, skid_d;

  logic accept;
  logic pop;

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      // Payload registers keep stale data; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so nothing can be accepted.
          if (pop) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Registered ready: next-cycle readiness depends only on next occupancy.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

endmodule

`default_nettype wire

// File: rtl/ex_mem_stage_reg.sv
//------------------------------------------------------------------------------
// Module   : ex_mem_stage_reg
// Purpose  : EX/MEM pipeline register. Captures ALU result, flags, control
//            and store data, computes zero (and optionally overflow trap) at
//            capture, and hands them to MEM through a 2-entry skid buffer.
// Ports    : clk, reset (async, active-high), flush (sync)
//            in_valid/in_ready + ALU/control/store inputs from EX
//            out_valid/out_ready + out_* registered copies, out_zero, out_trap
// Config   : EX_MEM_OVERFLOW_TRAP_EN - when defined, out_trap = overflow &
//            is_addsub and a trapping entry has reg_write/mem_read/mem_write
//            forced low. Otherwise out_trap is constant 0.
// Note     : XLEN / REG_ADDR_W must match XLEN_DEF / REG_ADDR_W_DEF, since
//            the payload struct is sized from the package constants.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ex_mem_stage_reg
  import ex_mem_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic                  alu_carry,
  input  logic                  alu_overflow,
  input  logic                  alu_set,
  input  logic [XLEN-1:0]       store_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_to_reg,
  input  logic                  is_addsub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_alu_result,
  output logic                  out_alu_carry,
  output logic                  out_alu_overflow,
  output logic                  out_alu_set,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_mem_to_reg,
  output logic                  out_is_addsub,
  output logic                  out_zero,
  output logic                  out_trap
);

  ex_mem_payload_t in_payload;
  ex_mem_payload_t out_payload;
  logic            trap;

`ifdef EX_MEM_OVERFLOW_TRAP_EN
  assign trap = alu_overflow & is_addsub;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    in_payload              = '0;
    in_payload.alu_result   = alu_result;
    in_payload.alu_carry    = alu_carry;
    in_payload.alu_overflow = alu_overflow;
    in_payload.alu_set      = alu_set;
    in_payload.store_data   = store_data;
    in_payload.rd           = rd;
    // A trapping instruction must not commit any architectural side effect.
    in_payload.reg_write    = reg_write & ~trap;
    in_payload.mem_read     = mem_read  & ~trap;
    in_payload.mem_write    = mem_write & ~trap;
    in_payload.mem_to_reg   = mem_to_reg;
    in_payload.is_addsub    = is_addsub;
    in_payload.zero         = (alu_result == '0);
    in_payload.trap         = trap;
  end

  ex_mem_skid u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  assign out_alu_result   = out_payload.alu_result;
  assign out_alu_carry    = out_payload.alu_carry;
  assign out_alu_overflow = out_payload.alu_overflow;
  assign out_alu_set      = out_payload.alu_set;
  assign out_store_data   = out_payload.store_data;
  assign out_rd           = out_payload.rd;
  assign out_reg_write    = out_payload.reg_write;
  assign out_mem_read     = out_payload.mem_read;
  assign out_mem_write    = out_payload.mem_write;
  assign out_mem_to_reg   = out_payload.mem_to_reg;
  assign out_is_addsub    = out_payload.is_addsub;
  assign out_zero         = out_payload.zero;
  assign out_trap         = out_payload.trap;

endmodule

`default_nettype wire
